// File: rtl/jtag_cmd_responder_if.sv
// Byte streams to/from the JTAG UART bridge plus the 8-bit register bus.
// The responder uses the slave side; whoever drives it uses master.
interface jtag_cmd_responder_if;
  logic [7:0] rx_din;
  logic       rx_vld;
  logic [7:0] tx_din;
  logic       tx_vld;
  logic       busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       cmd_active;
  logic [7:0] drop_cnt;

  modport slave (
    input  rx_din, rx_vld, busy, reg_rdata, reg_ack,
    output tx_din, tx_vld, reg_addr, reg_wdata, reg_wr, reg_rd, cmd_active, drop_cnt
  );

  modport master (
    output rx_din, rx_vld, busy, reg_rdata, reg_ack,
    input  tx_din, tx_vld, reg_addr, reg_wdata, reg_wr, reg_rd, cmd_active, drop_cnt
  );
endinterface

// File: rtl/jtag_cmd_responder.sv
// Parses 5-byte host command frames, performs one register access and
// returns a 4-byte response frame.
//
// state  | meaning
// IDLE   | hunting for the 0xA5 sync byte
// OP     | waiting for opcode byte
// ADDR   | waiting for address byte
// DATA   | waiting for data byte
// CHK    | waiting for checksum byte, then evaluate
// EXEC   | strobe issued, waiting for reg_ack or bus timeout
// RESP   | emitting 0x5A, STATUS, RDATA, CHK
module jtag_cmd_responder #(
  parameter int BUS_TIMEOUT = 255,
  parameter int RX_TIMEOUT  = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  jtag_cmd_responder_if.slave bus
);
  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int RT_W = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_OP, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RESP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_op;
  logic [7:0]      r_addr_b;
  logic [7:0]      r_data_b;
  logic [7:0]      r_status;
  logic [7:0]      r_rdata;
  logic [1:0]      r_idx;
  logic            r_tx_vld;
  logic [7:0]      r_tx_din;
  logic [7:0]      r_reg_addr;
  logic [7:0]      r_reg_wdata;
  logic            r_reg_wr;
  logic            r_reg_rd;
  logic [7:0]      r_drop_cnt;
  logic [RT_W-1:0] r_rx_tmr;
  logic [BT_W-1:0] r_bus_tmr;

  logic [7:0] w_chk;
  logic [1:0] w_next_idx;
  logic [7:0] w_next_byte;
  logic       w_in_frame;
  logic       w_rx_exp;

  assign w_chk      = r_op ^ r_addr_b ^ r_data_b;
  assign w_next_idx = r_idx + 2'd1;
  assign w_in_frame = (r_state == S_OP) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CHK);
  assign w_rx_exp   = (r_rx_tmr == '0);

  always_comb begin
    w_next_byte = 8'h5A;
    case (w_next_idx)
      2'd1:    w_next_byte = r_status;
      2'd2:    w_next_byte = r_rdata;
      2'd3:    w_next_byte = r_status ^ r_rdata;
      default: w_next_byte = 8'h5A;
    endcase
  end

  // The presented byte is only strobed while the bridge can take it, so a
  // stalled byte stays put until busy drops.
  assign bus.tx_vld     = r_tx_vld & ~bus.busy;
  assign bus.tx_din     = r_tx_din;
  assign bus.reg_addr   = r_reg_addr;
  assign bus.reg_wdata  = r_reg_wdata;
  assign bus.reg_wr     = r_reg_wr;
  assign bus.reg_rd     = r_reg_rd;
  assign bus.cmd_active = (r_state != S_IDLE);
  assign bus.drop_cnt   = r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_addr_b    <= '0;
      r_data_b    <= '0;
      r_status    <= '0;
      r_rdata     <= '0;
      r_idx       <= '0;
      r_tx_vld    <= 1'b0;
      r_tx_din    <= '0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_drop_cnt  <= '0;
      r_rx_tmr    <= '0;
      r_bus_tmr   <= '0;
    end else begin
      r_reg_wr <= 1'b0;
      r_reg_rd <= 1'b0;

      if (bus.rx_vld && (r_state == S_EXEC || r_state == S_RESP) && r_drop_cnt != 8'hFF)
        r_drop_cnt <= r_drop_cnt + 8'd1;

      if (w_in_frame) begin
        if (bus.rx_vld)
          r_rx_tmr <= RT_W'(RX_TIMEOUT - 1);
        else if (!w_rx_exp)
          r_rx_tmr <= r_rx_tmr - RT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (bus.rx_vld && bus.rx_din == 8'hA5) begin
            r_state  <= S_OP;
            r_rx_tmr <= RT_W'(RX_TIMEOUT - 1);
          end
        end
        S_OP: begin
          if (bus.rx_vld) begin
            r_op    <= bus.rx_din;
            r_state <= S_ADDR;
          end else if (w_rx_exp) begin
            r_state <= S_IDLE;
          end
        end
        S_ADDR: begin
          if (bus.rx_vld) begin
            r_addr_b <= bus.rx_din;
            r_state  <= S_DATA;
          end else if (w_rx_exp) begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (bus.rx_vld) begin
            r_data_b <= bus.rx_din;
            r_state  <= S_CHK;
          end else if (w_rx_exp) begin
            r_state <= S_IDLE;
          end
        end
        S_CHK: begin
          if (bus.rx_vld) begin
            r_idx <= '0;
            if (bus.rx_din != w_chk) begin
              r_status <= 8'h01;
              r_rdata  <= '0;
              r_state  <= S_RESP;
            end else if (r_op != 8'h01 && r_op != 8'h02) begin
              r_status <= 8'h02;
              r_rdata  <= '0;
              r_state  <= S_RESP;
            end else begin
              r_reg_addr  <= r_addr_b;
              r_reg_wdata <= r_data_b;
              r_reg_wr    <= (r_op == 8'h01);
              r_reg_rd    <= (r_op == 8'h02);
              r_bus_tmr   <= BT_W'(BUS_TIMEOUT);
              r_state     <= S_EXEC;
            end
          end else if (w_rx_exp) begin
            r_state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (bus.reg_ack) begin
            r_status <= 8'h00;
            r_rdata  <= (r_op == 8'h02) ? bus.reg_rdata : r_reg_wdata;
            r_idx    <= '0;
            r_tx_vld <= 1'b1;
            r_tx_din <= 8'h5A;
            r_state  <= S_RESP;
          end else if (r_bus_tmr == '0) begin
            r_status <= 8'h03;
            r_rdata  <= '0;
            r_idx    <= '0;
            r_tx_vld <= 1'b1;
            r_tx_din <= 8'h5A;
            r_state  <= S_RESP;
          end else begin
            r_bus_tmr <= r_bus_tmr - BT_W'(1);
          end
        end
        S_RESP: begin
          // Error responses arrive here with nothing presented yet.
          if (!r_tx_vld) begin
            r_tx_vld <= 1'b1;
            r_tx_din <= 8'h5A;
          end else if (!bus.busy) begin
            if (r_idx == 2'd3) begin
              r_tx_vld <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_idx    <= w_next_idx;
              r_tx_din <= w_next_byte;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_cmd_responder.sv
// Directed bench for jtag_cmd_responder: response bytes are checked against
// a scoreboard queue filled when each command frame is sent.
module tb_jtag_cmd_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtag_cmd_responder_if bus ();

  jtag_cmd_responder #(.BUS_TIMEOUT(16), .RX_TIMEOUT(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  int         n_tx = 0, n_wr = 0, n_rd = 0;
  time        t_first = 0, t_last = 0, t_strobe = 0, t_chk = 0;
  bit         got_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.reg_wr) n_wr++;
      if (bus.reg_rd) n_rd++;
      if (bus.reg_wr || bus.reg_rd) t_strobe = $time;
      if (bus.tx_vld) begin
        logic [7:0] e;
        n_tx++;
        chk("tx_while_busy", 32'(bus.busy), 32'd0);
        if (!got_first) begin
          got_first = 1'b1;
          t_first = $time;
        end
        t_last = $time;
        chk("tx_expected_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("tx_byte", 32'(bus.tx_din), 32'(e));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_din = b;
    bus.rx_vld = 1'b1;
    t_chk = $time + 4;
    @(posedge clk); #1;
    bus.rx_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] addr,
                            input logic [7:0] data, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(addr);
    send_byte(data);
    send_byte(c);
  endtask

  task automatic push_resp(input logic [7:0] st, input logic [7:0] rd);
    sb.push_back(8'h5A);
    sb.push_back(st);
    sb.push_back(rd);
    sb.push_back(st ^ rd);
    got_first = 1'b0;
  endtask

  task automatic wait_strobe();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.reg_wr || bus.reg_rd) begin
        ok = 1'b1;
        break;
      end
    end
    chk("strobe_seen", 32'(ok), 32'd1);
  endtask

  task automatic ack_after(input int n, input logic [7:0] rdata);
    repeat (n) begin
      @(posedge clk); #1;
    end
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = rdata;
    @(posedge clk); #1;
    bus.reg_ack   = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.cmd_active) begin
        done = 1'b1;
        break;
      end
    end
    chk("resp_done", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int s0, tx0, wr0, rd0;
    bus.rx_din = '0; bus.rx_vld = 1'b0; bus.busy = 1'b0;
    bus.reg_rdata = '0; bus.reg_ack = 1'b0;

    repeat (3) @(posedge clk); #1;
    chk("rst_tx", 32'({bus.tx_vld, bus.tx_din, bus.reg_wr, bus.reg_rd, bus.cmd_active}), 32'd0);
    chk("rst_reg", 32'({bus.reg_addr, bus.reg_wdata, bus.drop_cnt}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write, ack two cycles after the strobe
    wr0 = n_wr;
    push_resp(8'h00, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    chk("cmd_active_exec", 32'(bus.cmd_active), 32'd1);
    wait_strobe();
    chk("wr_strobe_kind", 32'({bus.reg_wr, bus.reg_rd}), 32'b10);
    chk("wr_addr", 32'(bus.reg_addr), 32'h10);
    chk("wr_wdata", 32'(bus.reg_wdata), 32'h3C);
    ack_after(2, 8'hEE);
    wait_idle();
    chk("wr_latency", 32'(t_first - t_strobe), 32'd30);
    chk("resp_back_to_back", 32'(t_last - t_first), 32'd30);
    chk("wr_count", 32'(n_wr - wr0), 32'd1);
    chk("cmd_active_idle", 32'(bus.cmd_active), 32'd0);

    // read
    rd0 = n_rd;
    push_resp(8'h00, 8'h7E);
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    wait_strobe();
    chk("rd_strobe_kind", 32'({bus.reg_wr, bus.reg_rd}), 32'b01);
    chk("rd_addr", 32'(bus.reg_addr), 32'h20);
    ack_after(1, 8'h7E);
    wait_idle();
    chk("rd_count", 32'(n_rd - rd0), 32'd1);

    // bad checksum
    s0 = n_wr + n_rd;
    push_resp(8'h01, 8'h00);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
    wait_idle();
    chk("err_latency", 32'(t_first - t_chk), 32'd20);

    // bad opcode
    push_resp(8'h02, 8'h00);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    wait_idle();
    chk("err_no_strobe", 32'(n_wr + n_rd - s0), 32'd0);
    chk("addr_hold", 32'(bus.reg_addr), 32'h20);

    // bus timeout
    push_resp(8'h03, 8'h00);
    send_frame(8'h02, 8'h33, 8'h00, 8'h31);
    wait_strobe();
    wait_idle();
    chk("timeout_latency", 32'(t_first - t_strobe), 32'd170);

    // drops during EXEC, backpressure during RESP
    chk("drop_zero", 32'(bus.drop_cnt), 32'd0);
    push_resp(8'h00, 8'h55);
    send_frame(8'h01, 8'h44, 8'h55, 8'h10);
    wait_strobe();
    @(posedge clk); #1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    bus.reg_ack = 1'b1;
    @(posedge clk); #1;
    bus.reg_ack = 1'b0;
    @(posedge clk); #1;
    bus.busy = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.busy = 1'b0;
    wait_idle();
    chk("drop_cnt", 32'(bus.drop_cnt), 32'd3);
    chk("bp_span", 32'(t_last - t_first), 32'd130);

    // inter-byte timeout resync
    tx0 = n_tx;
    send_byte(8'hA5);
    send_byte(8'h01);
    chk("cmd_active_midframe", 32'(bus.cmd_active), 32'd1);
    repeat (60) begin
      @(posedge clk); #1;
    end
    chk("resync_idle", 32'(bus.cmd_active), 32'd0);
    push_resp(8'h00, 8'h3C);
    send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
    wait_strobe();
    ack_after(1, 8'h00);
    wait_idle();
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("resync_tx_count", 32'(n_tx - tx0), 32'd4);

    // reset in the middle of a response
    push_resp(8'h00, 8'h66);
    send_frame(8'h01, 8'h70, 8'h66, 8'h17);
    wait_strobe();
    ack_after(1, 8'h00);
    bus.busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", 32'({bus.tx_vld, bus.tx_din, bus.reg_wr, bus.reg_rd, bus.cmd_active}), 32'd0);
    chk("rst_mid_reg", 32'({bus.reg_addr, bus.reg_wdata, bus.drop_cnt}), 32'd0);
    tx0 = n_tx;
    sb.delete();
    bus.busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("post_reset_tx", 32'(n_tx - tx0), 32'd0);
    chk("post_reset_idle", 32'(bus.cmd_active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/jtag_cmd_responder.md
# jtag_cmd_responder

Command responder sitting on the FPGA side of the JTAG UART bridge. It consumes host bytes from the bridge's receive stream (`rx_din`/`rx_vld`) and parses fixed 5-byte command frames. For each frame it performs one 8-bit register-bus read or write and returns a 4-byte response frame through the bridge's transmit stream (`tx_din`/`tx_vld`), honouring `busy`.

## Interface
- `BUS_TIMEOUT`, default 255: cycles to wait for `reg_ack` after a strobe before reporting a timeout.
- `RX_TIMEOUT`, default 1000000: idle cycles allowed between bytes of one command frame before the parser resyncs.
- `clk` in 1: system clock. The only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_din` in 8: host byte from the bridge.
- `rx_vld` in 1: one-cycle strobe, `rx_din` valid.
- `tx_din` out 8: response byte to the bridge.
- `tx_vld` out 1: one-cycle strobe, `tx_din` valid.
- `busy` in 1: bridge to-host FIFO full; a byte strobed while high is lost.
- `reg_addr` out 8: register address.
- `reg_wdata` out 8: write data.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_rdata` in 8: read data, sampled on `reg_ack`.
- `reg_ack` in 1: access complete.
- `cmd_active` out 1: high in every state except IDLE.
- `drop_cnt` out 8: saturating count of bytes discarded while in EXEC or RESP.

## Operation
- Command frame bytes, in order: `0xA5`, OP, ADDR, DATA, CHK, where CHK = OP^ADDR^DATA. OP `0x01` = write, OP `0x02` = read. DATA is ignored for reads but still required.
- Response frame bytes, in order: `0x5A`, STATUS, RDATA, CHK, where CHK = STATUS^RDATA.
  - STATUS: `0x00` ok, `0x01` bad checksum, `0x02` bad opcode, `0x03` bus timeout.
  - RDATA: write data echo for an ok write, read data for an ok read, `0x00` on any error.
- State machine:
  - IDLE: on `rx_vld` with `0xA5` → OP. Any other byte is ignored and not counted.
  - OP, ADDR, DATA: on `rx_vld`, latch the byte and advance. A `0xA5` byte in these states is treated as data.
  - CHK: on `rx_vld`, evaluate. Checksum is checked first, then opcode. On error → RESP with no bus access. On ok → EXEC.
  - EXEC: on entry, pulse `reg_wr` or `reg_rd` for one cycle with `reg_addr`/`reg_wdata` stable. Then wait for `reg_ack` → RESP (ok), or `BUS_TIMEOUT` cycles without ack → RESP (STATUS `0x03`).
  - RESP: emit the 4 response bytes, then → IDLE.
- Inter-byte timeout: in OP..CHK, a counter restarts on every `rx_vld`. It reaches `RX_TIMEOUT` with no `rx_vld` that cycle → IDLE silently, no response. An `rx_vld` in the expiry cycle is accepted.
- `reg_addr`/`reg_wdata` hold their last values outside EXEC.
- `reg_ack` outside EXEC is ignored. `reg_ack` in the same cycle as timeout expiry: ack wins.
- `rx_vld` in EXEC or RESP: the byte is discarded and `drop_cnt` increments, saturating at 255.
- Counter widths are `$clog2(param+1)`.
- Reset, asynchronous: all outputs are 0 (`tx_vld`, `tx_din`, `reg_wr`, `reg_rd`, `reg_addr`, `reg_wdata`, `cmd_active`, `drop_cnt`), state is IDLE, and all counters clear. Reset mid-frame or mid-response abandons it; no partial bytes are emitted after release.

## Timing
- `tx_vld` is asserted only in cycles where `busy`=0. With `busy` held low, the 4 response bytes go out on 4 consecutive cycles.
- `busy` high stalls the current byte; no byte is skipped or repeated.
- Error path: the first response byte appears 2 cycles after the CHK `rx_vld` cycle.
- Ok path: the `reg_wr`/`reg_rd` strobe occurs 1 cycle after the CHK `rx_vld`. The first response byte appears 1 cycle after the `reg_ack` cycle.
- Timeout: the strobe is at cycle s. With no ack, the first response byte appears at s+`BUS_TIMEOUT`+1.
- `reg_rdata` is captured in the `reg_ack` cycle only.
- `cmd_active` rises the cycle after the `0xA5` is accepted and falls the cycle after the 4th response byte.

## Test plan
- Write: send `A5 01 10 3C 2D` with ack 2 cycles after the strobe → one `reg_wr` with addr `0x10`, wdata `0x3C`; response `5A 00 3C 3C`.
- Read: send `A5 02 20 00 22` with `reg_rdata`=`0x7E` on ack → one `reg_rd` with addr `0x20`; response `5A 00 7E 7E`.
- Errors: send `A5 01 10 3C 00` → no strobe, response `5A 01 00 01`. Send `A5 07 00 00 07` → response `5A 02 00 02`.
- Bus timeout: with `BUS_TIMEOUT`=16 and no ack, send a read → response `5A 03 00 03`, first byte at strobe+17.
- Backpressure and drops: hold `busy` high for 10 cycles during RESP and send 3 bytes during EXEC → response bytes intact and in order, no `tx_vld` while busy, `drop_cnt`=3.
- Resync and reset: with `RX_TIMEOUT`=50, send `A5 01`, wait 60 cycles, then send a full valid frame → only one response. Assert `rst_n` during RESP → outputs go to 0 immediately and no trailing bytes appear.
